// File: rtl/idli_pkg.sv
// Shared types for the idli front end: opcodes, decoded op layout and decoder states.
// Every other rtl/ file imports this package.
package idli_pkg;

    typedef logic [3:0]  sqi_data_t;
    typedef logic [3:0]  greg_t;
    typedef logic [15:0] insn_t;

    localparam int INSN_NIBBLES = 4;
    localparam int OPC_IMM_BIT  = 3;
    localparam logic [1:0] CTR_LAST = 2'(INSN_NIBBLES - 1);

    // Upper half of the opcode space mirrors the lower half, with an immediate RHS.
    typedef enum logic [3:0] {
        OPC_ADD  = 4'h0, OPC_SUB  = 4'h1, OPC_AND  = 4'h2, OPC_OR   = 4'h3,
        OPC_XOR  = 4'h4, OPC_ANDN = 4'h5, OPC_MOV  = 4'h6, OPC_NOP  = 4'h7,
        OPC_ADDI = 4'h8, OPC_SUBI = 4'h9, OPC_ANDI = 4'hA, OPC_ORI  = 4'hB,
        OPC_XORI = 4'hC, OPC_ANDNI = 4'hD, OPC_MOVI = 4'hE, OPC_NOPI = 4'hF
    } opc_t;

    typedef enum logic [1:0] {
        ALU_OP_ADD = 2'd0,
        ALU_OP_AND = 2'd1,
        ALU_OP_OR  = 2'd2,
        ALU_OP_XOR = 2'd3
    } alu_op_t;

    typedef enum logic {
        LHS_SRC_REG  = 1'b0,
        LHS_SRC_ZERO = 1'b1
    } lhs_src_t;

    typedef enum logic {
        RHS_SRC_REG = 1'b0,
        RHS_SRC_IMM = 1'b1
    } rhs_src_t;

    typedef struct packed {
        alu_op_t  alu_op;
        logic     inv;
        logic     cin;
        lhs_src_t lhs_src;
        rhs_src_t rhs_src;
        greg_t    a;
        logic     a_vld;
        greg_t    b;
        greg_t    c;
    } op_t;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        ISSUE = 2'd1,
        SKIP  = 2'd2
    } de_state_t;

endpackage

// File: rtl/idli_dec_m.sv
// Purely combinational instruction decoder: 16b instruction word in, op_t out.
module idli_dec_m
    import idli_pkg::*;
(
    input  logic [15:0] insn,
    output op_t         op
);

    greg_t nib [INSN_NIBBLES];
    opc_t  opc;
    logic  is_imm;

    genvar gi;
    generate
        for (gi = 0; gi < INSN_NIBBLES; gi++) begin : g_nib
            assign nib[gi] = insn[gi*4 +: 4];
        end
    endgenerate

    assign opc    = opc_t'(nib[INSN_NIBBLES-1]);
    assign is_imm = nib[INSN_NIBBLES-1][OPC_IMM_BIT];

    always_comb begin
        op         = '0;
        op.alu_op  = ALU_OP_ADD;
        op.inv     = 1'b0;
        op.cin     = 1'b0;
        op.lhs_src = LHS_SRC_REG;
        op.rhs_src = is_imm ? RHS_SRC_IMM : RHS_SRC_REG;
        op.a       = nib[2];
        op.a_vld   = 1'b1;
        op.b       = nib[1];
        // The c slot is the immediate's position on the bus, not a register.
        op.c       = is_imm ? 4'h0 : nib[0];

        case (opc)
            OPC_SUB,  OPC_SUBI:  begin op.inv = 1'b1; op.cin = 1'b1; end
            OPC_AND,  OPC_ANDI:  op.alu_op = ALU_OP_AND;
            OPC_OR,   OPC_ORI:   op.alu_op = ALU_OP_OR;
            OPC_XOR,  OPC_XORI:  op.alu_op = ALU_OP_XOR;
            OPC_ANDN, OPC_ANDNI: begin op.alu_op = ALU_OP_AND; op.inv = 1'b1; end
            OPC_MOV,  OPC_MOVI:  op.lhs_src = LHS_SRC_ZERO;
            OPC_NOP,  OPC_NOPI:  op.a_vld = 1'b0;
            default: ;
        endcase
    end

endmodule

// File: rtl/idli_de_m.sv
// Fetch/decode front end: gathers four SQI nibbles, decodes, holds the op until
// accepted, then lets immediate nibbles pass through to the execution unit.
module idli_de_m
    import idli_pkg::*;
(
    input  logic       i_de_gck,
    input  logic       i_de_rst,
    input  logic [3:0] i_de_sqi_data,
    input  logic       i_de_sqi_vld,
    output logic       o_de_sqi_rdy,
    output op_t        o_de_op,
    output logic       o_de_op_vld,
    input  logic       i_de_op_acp
);

    de_state_t   state_reg, state_next;
    logic [1:0]  ctr_reg,   ctr_next;
    logic [15:0] shift_reg, shift_next;
    op_t         op_reg,    op_next;

    logic [15:0] insn_full;
    op_t         dec_op;
    logic        xfer;

    // The word is decoded on the last transfer, so splice in the live nibble.
    assign insn_full = {shift_reg[11:0], i_de_sqi_data};

    idli_dec_m u_dec (
        .insn (insn_full),
        .op   (dec_op)
    );

    always_comb begin
        state_next   = state_reg;
        ctr_next     = ctr_reg;
        shift_next   = shift_reg;
        op_next      = op_reg;
        o_de_sqi_rdy = (state_reg != ISSUE);
        o_de_op_vld  = (state_reg == ISSUE);
        xfer         = i_de_sqi_vld && o_de_sqi_rdy;

        case (state_reg)
            FETCH: begin
                if (xfer) begin
                    shift_next = insn_full;
                    ctr_next   = ctr_reg + 2'd1;
                    if (ctr_reg == CTR_LAST) begin
                        op_next    = dec_op;
                        state_next = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (i_de_op_acp) begin
                    state_next = (op_reg.rhs_src == RHS_SRC_IMM) ? SKIP : FETCH;
                end
            end
            SKIP: begin
                if (xfer) begin
                    ctr_next = ctr_reg + 2'd1;
                    if (ctr_reg == CTR_LAST) begin
                        state_next = FETCH;
                    end
                end
            end
            default: state_next = FETCH;
        endcase
    end

    always_ff @(posedge i_de_gck) begin
        if (i_de_rst) begin
            state_reg <= FETCH;
            ctr_reg   <= 2'd0;
            shift_reg <= 16'h0000;
        end else begin
            state_reg <= state_next;
            ctr_reg   <= ctr_next;
            shift_reg <= shift_next;
        end
    end

    // Only meaningful while ISSUE is held, so it carries no reset.
    always_ff @(posedge i_de_gck) begin
        op_reg <= op_next;
    end

    assign o_de_op = op_reg;

endmodule

// File: tb/tb_idli_de_m.sv
// Self-checking bench for idli_de_m: table of instructions plus hand-built
// sequences for gaps and reset corner cases; expected ops go through a queue.
module tb_idli_de_m;
    import idli_pkg::*;

    logic       clk;
    logic       rst;
    logic [3:0] sqi_data;
    logic       sqi_vld;
    logic       sqi_rdy;
    op_t        de_op;
    logic       op_vld;
    logic       op_acp;

    int n_cmp;
    int n_mis;
    int cyc;
    op_t sb[$];

    idli_de_m dut (
        .i_de_gck      (clk),
        .i_de_rst      (rst),
        .i_de_sqi_data (sqi_data),
        .i_de_sqi_vld  (sqi_vld),
        .o_de_sqi_rdy  (sqi_rdy),
        .o_de_op       (de_op),
        .o_de_op_vld   (op_vld),
        .i_de_op_acp   (op_acp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] insn;
        int          hold;
        op_t         exp;
    } vec_t;

    vec_t tbl [12];

    function automatic op_t mk(alu_op_t alu, logic inv, logic cin, lhs_src_t lhs,
                               rhs_src_t rhs, logic [3:0] a, logic [3:0] b,
                               logic [3:0] c, logic av);
        op_t o;
        o.alu_op  = alu;
        o.inv     = inv;
        o.cin     = cin;
        o.lhs_src = lhs;
        o.rhs_src = rhs;
        o.a       = a;
        o.a_vld   = av;
        o.b       = b;
        o.c       = c;
        return o;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic bound_fail(input string name);
        n_cmp++;
        n_mis++;
        $display("FAIL %s: wait bound expired, got nothing expected event (t=%0t)", name, $time);
    endtask

    // Called at a negedge; returns at the negedge after the transfer edge.
    task automatic xfer(input logic [3:0] n);
        int t;
        t = 0;
        sqi_data = n;
        sqi_vld  = 1'b1;
        while (!sqi_rdy && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!sqi_rdy) bound_fail("xfer_rdy_timeout");
        @(negedge clk);
        sqi_vld = 1'b0;
    endtask

    task automatic send_insn(input logic [15:0] insn, input op_t exp);
        logic [15:0] w;
        w = insn;
        sb.push_back(exp);
        for (int i = 3; i >= 0; i--) xfer(w[i*4 +: 4]);
    endtask

    task automatic wait_op();
        int  t;
        op_t exp;
        t = 0;
        while (!op_vld && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!op_vld) begin
            bound_fail("op_timeout");
            return;
        end
        if (sb.size() == 0) begin
            bound_fail("unexpected_op");
            return;
        end
        exp = sb.pop_front();
        chk("op", {13'b0, de_op}, {13'b0, exp});
        chk("rdy_in_issue", {31'b0, sqi_rdy}, 32'd0);
        $display("txn op=0x%05h pending=%0d", de_op, sb.size());
    endtask

    task automatic accept(input int hold);
        op_t held;
        held = de_op;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_op",  {13'b0, de_op}, {13'b0, held});
            chk("hold_vld", {31'b0, op_vld}, 32'd1);
            chk("hold_rdy", {31'b0, sqi_rdy}, 32'd0);
        end
        op_acp = 1'b1;
        @(negedge clk);
        op_acp = 1'b0;
        chk("post_acp_rdy", {31'b0, sqi_rdy}, 32'd1);
        chk("post_acp_vld", {31'b0, op_vld}, 32'd0);
    endtask

    initial begin
        int c0;
        n_cmp    = 0;
        n_mis    = 0;
        rst      = 1'b1;
        sqi_vld  = 1'b0;
        sqi_data = 4'h0;
        op_acp   = 1'b0;

        tbl[0]  = '{16'h0123, 0,  mk(ALU_OP_ADD, 0, 0, LHS_SRC_REG,  RHS_SRC_REG, 4'h1, 4'h2, 4'h3, 1)};
        tbl[1]  = '{16'h1234, 10, mk(ALU_OP_ADD, 1, 1, LHS_SRC_REG,  RHS_SRC_REG, 4'h2, 4'h3, 4'h4, 1)};
        tbl[2]  = '{16'h2ABC, 1,  mk(ALU_OP_AND, 0, 0, LHS_SRC_REG,  RHS_SRC_REG, 4'hA, 4'hB, 4'hC, 1)};
        tbl[3]  = '{16'h3DEF, 0,  mk(ALU_OP_OR,  0, 0, LHS_SRC_REG,  RHS_SRC_REG, 4'hD, 4'hE, 4'hF, 1)};
        tbl[4]  = '{16'h4567, 2,  mk(ALU_OP_XOR, 0, 0, LHS_SRC_REG,  RHS_SRC_REG, 4'h5, 4'h6, 4'h7, 1)};
        tbl[5]  = '{16'h589A, 0,  mk(ALU_OP_AND, 1, 0, LHS_SRC_REG,  RHS_SRC_REG, 4'h8, 4'h9, 4'hA, 1)};
        tbl[6]  = '{16'h6700, 0,  mk(ALU_OP_ADD, 0, 0, LHS_SRC_ZERO, RHS_SRC_REG, 4'h7, 4'h0, 4'h0, 1)};
        tbl[7]  = '{16'h7000, 0,  mk(ALU_OP_ADD, 0, 0, LHS_SRC_REG,  RHS_SRC_REG, 4'h0, 4'h0, 4'h0, 0)};
        tbl[8]  = '{16'h8560, 0,  mk(ALU_OP_ADD, 0, 0, LHS_SRC_REG,  RHS_SRC_IMM, 4'h5, 4'h6, 4'h0, 1)};
        tbl[9]  = '{16'h9F3C, 3,  mk(ALU_OP_ADD, 1, 1, LHS_SRC_REG,  RHS_SRC_IMM, 4'hF, 4'h3, 4'h0, 1)};
        tbl[10] = '{16'hE120, 0,  mk(ALU_OP_ADD, 0, 0, LHS_SRC_ZERO, RHS_SRC_IMM, 4'h1, 4'h2, 4'h0, 1)};
        tbl[11] = '{16'hC456, 0,  mk(ALU_OP_XOR, 0, 0, LHS_SRC_REG,  RHS_SRC_IMM, 4'h4, 4'h5, 4'h0, 1)};

        repeat (3) @(negedge clk);
        chk("reset_vld", {31'b0, op_vld}, 32'd0);
        chk("reset_rdy", {31'b0, sqi_rdy}, 32'd1);
        rst = 1'b0;

        // Table: each op must be visible the cycle after its 4th nibble.
        for (int i = 0; i < 12; i++) begin
            send_insn(tbl[i].insn, tbl[i].exp);
            chk("issue_latency", {31'b0, op_vld}, 32'd1);
            wait_op();
            accept(tbl[i].hold);
            if (tbl[i].insn[15]) begin
                for (int k = 0; k < 4; k++) xfer(4'hF);
                chk("skip_no_issue", {31'b0, op_vld}, 32'd0);
                chk("skip_done_rdy", {31'b0, sqi_rdy}, 32'd1);
            end
        end

        // One idle cycle between every nibble: 4 transfers + 3 gaps, then issue.
        sb.push_back(mk(ALU_OP_ADD, 0, 0, LHS_SRC_ZERO, RHS_SRC_REG, 4'h7, 4'h0, 4'h0, 1));
        c0 = cyc;
        begin
            logic [15:0] w;
            w = 16'h6700;
            for (int i = 3; i >= 0; i--) begin
                xfer(w[i*4 +: 4]);
                if (i > 0) @(negedge clk);
            end
        end
        chk("gap_cycles", 32'(cyc - c0), 32'd7);
        chk("gap_vld", {31'b0, op_vld}, 32'd1);
        wait_op();
        accept(0);

        // Reset after two nibbles of 0x4ABC: the partial word must be discarded.
        xfer(4'h4);
        xfer(4'hA);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midfetch_rst_vld", {31'b0, op_vld}, 32'd0);
        chk("midfetch_rst_rdy", {31'b0, sqi_rdy}, 32'd1);
        send_insn(16'h7000, mk(ALU_OP_ADD, 0, 0, LHS_SRC_REG, RHS_SRC_REG, 4'h0, 4'h0, 4'h0, 0));
        chk("nop_latency", {31'b0, op_vld}, 32'd1);
        wait_op();
        accept(0);

        // Reset together with acceptance of an immediate op: no SKIP afterwards.
        send_insn(16'h8560, mk(ALU_OP_ADD, 0, 0, LHS_SRC_REG, RHS_SRC_IMM, 4'h5, 4'h6, 4'h0, 1));
        wait_op();
        rst    = 1'b1;
        op_acp = 1'b1;
        @(negedge clk);
        rst    = 1'b0;
        op_acp = 1'b0;
        chk("issue_rst_vld", {31'b0, op_vld}, 32'd0);
        chk("issue_rst_rdy", {31'b0, sqi_rdy}, 32'd1);
        send_insn(16'h0123, mk(ALU_OP_ADD, 0, 0, LHS_SRC_REG, RHS_SRC_REG, 4'h1, 4'h2, 4'h3, 1));
        chk("post_rst_latency", {31'b0, op_vld}, 32'd1);
        wait_op();
        accept(0);

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
